// File: rtl/spi_pixel_rx.sv
// SPI slave pixel receiver: oversamples sclk/sdi/ncs in the clk domain, deserialises
// PIX_W-bit pixels, tags them with a linear frame address and queues them in a small FIFO.
module spi_pixel_rx #(
  parameter int PIX_W            = 8,
  parameter int IMG_W            = 160,
  parameter int IMG_H            = 120,
  parameter int FIFO_DEPTH       = 4,
  parameter int MSB_FIRST        = 1,
  parameter int ADDR_RESET_ON_CS = 1,
  localparam int ADDR_W          = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              sdi,
  input  logic              ncs,
  output logic [PIX_W-1:0]  pix_data,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              frame_done,
  output logic              overflow,
  output logic              partial_drop
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = (PIX_W > 1) ? $clog2(PIX_W) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(PIX_W - 1);
  localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Pin synchronisers and edge detection (third copy is the edge reference)
  // ---------------------------------------------------------------------------
  logic sclk_s1, sclk_s2, sclk_prev;
  logic sdi_s1, sdi_s2;
  logic ncs_s1, ncs_s2, ncs_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_s1   <= 1'b0;
      sclk_s2   <= 1'b0;
      sclk_prev <= 1'b0;
      sdi_s1    <= 1'b0;
      sdi_s2    <= 1'b0;
      ncs_s1    <= 1'b1;
      ncs_s2    <= 1'b1;
      ncs_prev  <= 1'b1;
    end else begin
      sclk_s1   <= sclk;
      sclk_s2   <= sclk_s1;
      sclk_prev <= sclk_s2;
      sdi_s1    <= sdi;
      sdi_s2    <= sdi_s1;
      ncs_s1    <= ncs;
      ncs_s2    <= ncs_s1;
      ncs_prev  <= ncs_s2;
    end
  end

  logic sclk_rise, ncs_rise, ncs_fall;

  assign sclk_rise = sclk_s2 & ~sclk_prev;
  assign ncs_rise  = ncs_s2 & ~ncs_prev;
  assign ncs_fall  = ~ncs_s2 & ncs_prev;

  // Events are registered once so bit capture and framing act in one common
  // stage; this also fixes the pin-to-push latency at four clk edges.
  logic cap_q, bit_q, ncs_rise_q, ncs_fall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_q      <= 1'b0;
      bit_q      <= 1'b0;
      ncs_rise_q <= 1'b0;
      ncs_fall_q <= 1'b0;
    end else begin
      cap_q      <= sclk_rise & ~ncs_s2;
      bit_q      <= sdi_s2;
      ncs_rise_q <= ncs_rise;
      ncs_fall_q <= ncs_fall;
    end
  end

  // ---------------------------------------------------------------------------
  // Deserialiser and address counter
  // ---------------------------------------------------------------------------
  logic [PIX_W-1:0]  shreg, shreg_next;
  logic [CNT_W-1:0]  bitcnt;
  logic [ADDR_W-1:0] addr;
  logic              word_done, drop;
  logic              push_q;
  logic [PIX_W-1:0]  push_data;
  logic [ADDR_W-1:0] push_addr;

  if (PIX_W == 1) begin : g_one
    assign shreg_next = bit_q;
  end else if (MSB_FIRST != 0) begin : g_msb
    assign shreg_next = {shreg[PIX_W-2:0], bit_q};
  end else begin : g_lsb
    assign shreg_next = {bit_q, shreg[PIX_W-1:1]};
  end

  assign word_done = cap_q && (bitcnt == LAST_BIT);
  // A word completing alongside the ncs rise still counts as complete.
  assign drop      = ncs_rise_q && (bitcnt != '0) && !word_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg        <= '0;
      bitcnt       <= '0;
      addr         <= '0;
      push_q       <= 1'b0;
      push_data    <= '0;
      push_addr    <= '0;
      partial_drop <= 1'b0;
    end else begin
      push_q       <= word_done;
      partial_drop <= drop;
      if (cap_q) begin
        shreg  <= shreg_next;
        bitcnt <= word_done ? '0 : bitcnt + CNT_W'(1);
      end
      if (word_done) begin
        push_data <= shreg_next;
        push_addr <= addr;
        addr      <= (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);
      end
      if (drop) begin
        shreg  <= '0;
        bitcnt <= '0;
      end
      if (ncs_fall_q && (ADDR_RESET_ON_CS != 0)) begin
        addr <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO. Handshake: an entry transfers on every clk edge where
  // pix_valid && pix_ready; pix_data/pix_addr are stable while pix_valid is high
  // and not yet accepted. Push and pop in one cycle both happen, even when full.
  // ---------------------------------------------------------------------------
  logic [PIX_W-1:0]  mem_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] mem_addr [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic              full, pop, do_push;

  assign full    = (count == FULL_CNT);
  assign pop     = pix_valid && pix_ready;
  assign do_push = push_q && (!full || pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_data[wr_ptr] <= push_data;
      mem_addr[wr_ptr] <= push_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
      if (push_q && full && !pop) overflow <= 1'b1;
      frame_done <= push_q && (push_addr == LAST_ADDR);
    end
  end

  assign pix_valid = (count != '0);
  assign pix_data  = pix_valid ? mem_data[rd_ptr] : '0;
  assign pix_addr  = pix_valid ? mem_addr[rd_ptr] : '0;

endmodule

// File: tb/tb_spi_pixel_rx.sv
// Directed bench for spi_pixel_rx: three DUT configurations share sclk/sdi, each with
// its own ncs; a negedge monitor pops pixels against an expected queue.
`timescale 1ns/1ps
module tb_spi_pixel_rx;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sclk = 1'b0;
  logic sdi = 1'b0;
  logic ncs_a = 1'b1, ncs_b = 1'b1, ncs_c = 1'b1;
  logic ready_a = 1'b1, ready_b = 1'b1, ready_c = 1'b1;

  logic [7:0]  data_a, data_b, data_c;
  logic [14:0] addr_a, addr_b;
  logic [2:0]  addr_c;
  logic valid_a, valid_b, valid_c;
  logic fd_a, fd_b, fd_c, ovf_a, ovf_b, ovf_c, pd_a, pd_b, pd_c;

  int vectors = 0;
  int miscompares = 0;
  logic [23:0] exp_q[$];
  int sel = 0;
  int fd_cnt = 0;
  int pd_cnt = 0;
  logic [15:0] fd_addr = '0;
  logic [15:0] exp_addr = '0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  spi_pixel_rx #(.PIX_W(8), .IMG_W(160), .IMG_H(120), .FIFO_DEPTH(4),
                 .MSB_FIRST(1), .ADDR_RESET_ON_CS(1)) dut_a (
    .clk(clk), .reset(reset), .sclk(sclk), .sdi(sdi), .ncs(ncs_a),
    .pix_data(data_a), .pix_addr(addr_a), .pix_valid(valid_a), .pix_ready(ready_a),
    .frame_done(fd_a), .overflow(ovf_a), .partial_drop(pd_a));

  spi_pixel_rx #(.PIX_W(8), .IMG_W(160), .IMG_H(120), .FIFO_DEPTH(4),
                 .MSB_FIRST(0), .ADDR_RESET_ON_CS(1)) dut_b (
    .clk(clk), .reset(reset), .sclk(sclk), .sdi(sdi), .ncs(ncs_b),
    .pix_data(data_b), .pix_addr(addr_b), .pix_valid(valid_b), .pix_ready(ready_b),
    .frame_done(fd_b), .overflow(ovf_b), .partial_drop(pd_b));

  spi_pixel_rx #(.PIX_W(8), .IMG_W(4), .IMG_H(2), .FIFO_DEPTH(4),
                 .MSB_FIRST(1), .ADDR_RESET_ON_CS(0)) dut_c (
    .clk(clk), .reset(reset), .sclk(sclk), .sdi(sdi), .ncs(ncs_c),
    .pix_data(data_c), .pix_addr(addr_c), .pix_valid(valid_c), .pix_ready(ready_c),
    .frame_done(fd_c), .overflow(ovf_c), .partial_drop(pd_c));

  logic        m_valid, m_ready, m_fd, m_pd;
  logic [7:0]  m_data;
  logic [15:0] m_addr;

  always_comb begin
    m_valid = valid_a; m_ready = ready_a; m_fd = fd_a; m_pd = pd_a;
    m_data = data_a; m_addr = {1'b0, addr_a};
    case (sel)
      1: begin
        m_valid = valid_b; m_ready = ready_b; m_fd = fd_b; m_pd = pd_b;
        m_data = data_b; m_addr = {1'b0, addr_b};
      end
      2: begin
        m_valid = valid_c; m_ready = ready_c; m_fd = fd_c; m_pd = pd_c;
        m_data = data_c; m_addr = {13'b0, addr_c};
      end
      default: ;
    endcase
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (m_valid && m_ready) begin
        check("pop_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("pixel", 32'({m_addr, m_data}), 32'(exp_q.pop_front()));
      end
      if (m_fd) begin
        fd_cnt++;
        fd_addr = m_addr;
      end
      if (m_pd) pd_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sdi = bits[i];
      #25 sclk = 1'b1;
      #25 sclk = 1'b0;
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7 - i];
    return r;
  endfunction

  // Sends one byte first-bit-first and records the expected pixel.
  task automatic send_word(input logic [7:0] w, input bit lsb_first, input int img);
    exp_q.push_back({exp_addr, lsb_first ? rev8(w) : w});
    exp_addr = 16'((exp_addr + 1) % img);
    send_bits({8'h00, w}, 8);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    exp_q.delete();
    exp_addr = '0;
    fd_cnt = 0;
    pd_cnt = 0;
    idle(2);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    idle(3);
    check("reset_a", 32'({valid_a, fd_a, ovf_a, pd_a, data_a, addr_a}), 32'd0);
    check("reset_b", 32'({valid_b, fd_b, ovf_b, pd_b, data_b, addr_b}), 32'd0);
    check("reset_c", 32'({valid_c, fd_c, ovf_c, pd_c, data_c, addr_c}), 32'd0);
    reset = 1'b0;
    idle(2);

    // Basic word and pin-to-push latency, MSB first
    sel = 0;
    ncs_a = 1'b0;
    idle(4);
    exp_q.push_back({16'd0, 8'hF0});
    send_bits(16'b111_1000, 7);
    sdi = 1'b0;
    #25 sclk = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1 check("latency_edge4_valid", 32'(valid_a), 32'd0);
    @(posedge clk);
    #1 check("latency_edge5_valid", 32'(valid_a), 32'd1);
    sclk = 1'b0;
    idle(3);
    ncs_a = 1'b1;
    wait_drain("drain_basic");

    // LSB-first ordering
    sel = 1;
    exp_addr = '0;
    ncs_b = 1'b0;
    idle(4);
    send_word(8'hF0, 1'b1, 19200);
    send_word(8'hAA, 1'b1, 19200);
    send_word(8'h55, 1'b1, 19200);
    idle(2);
    ncs_b = 1'b1;
    wait_drain("drain_lsb");

    // Small frame: address persists across ncs, wraps, frame_done once
    sel = 2;
    exp_addr = '0;
    fd_cnt = 0;
    ncs_c = 1'b0;
    idle(4);
    for (int i = 0; i < 5; i++) send_word(8'($urandom_range(0, 255)), 1'b0, 8);
    idle(2);
    ncs_c = 1'b1;
    idle(10);
    ncs_c = 1'b0;
    idle(4);
    for (int i = 0; i < 4; i++) send_word(8'($urandom_range(0, 255)), 1'b0, 8);
    idle(2);
    ncs_c = 1'b1;
    wait_drain("drain_frame");
    idle(4);
    check("frame_done_count", 32'(fd_cnt), 32'd1);
    check("frame_done_addr", 32'(fd_addr), 32'd7);

    // Overflow with a stalled consumer
    sel = 0;
    do_reset();
    ready_a = 1'b0;
    ncs_a = 1'b0;
    idle(4);
    for (int i = 0; i < 4; i++) send_word(8'(8'h10 + i), 1'b0, 19200);
    idle(8);
    check("ovf_after_4", 32'(ovf_a), 32'd0);
    check("valid_when_full", 32'(valid_a), 32'd1);
    send_bits(16'h00E5, 8);
    idle(8);
    check("ovf_after_5", 32'(ovf_a), 32'd1);
    send_bits(16'h00E6, 8);
    idle(8);
    exp_addr = 16'd6;
    ready_a = 1'b1;
    wait_drain("drain_overflow");
    idle(2);
    check("empty_after_drain", 32'(valid_a), 32'd0);
    send_word(8'h77, 1'b0, 19200);
    wait_drain("drain_after_overflow");
    check("ovf_sticky", 32'(ovf_a), 32'd1);
    idle(2);
    ncs_a = 1'b1;
    idle(6);

    // Partial word dropped on ncs rise; address restarts on next transaction
    do_reset();
    ncs_a = 1'b0;
    idle(4);
    send_word(8'h3C, 1'b0, 19200);
    wait_drain("drain_before_partial");
    send_bits(16'h0015, 5);
    idle(2);
    ncs_a = 1'b1;
    idle(10);
    check("partial_drop_count", 32'(pd_cnt), 32'd1);
    check("no_push_on_partial", 32'(valid_a), 32'd0);
    exp_addr = '0;
    ncs_a = 1'b0;
    idle(4);
    send_word(8'hC3, 1'b0, 19200);
    idle(2);
    ncs_a = 1'b1;
    wait_drain("drain_after_partial");
    idle(6);
    check("partial_drop_once", 32'(pd_cnt), 32'd1);

    // Reset in the middle of a word
    do_reset();
    ncs_a = 1'b0;
    idle(4);
    send_bits(16'h0005, 3);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    exp_q.delete();
    exp_addr = '0;
    pd_cnt = 0;
    idle(4);
    send_word(8'h9A, 1'b0, 19200);
    idle(2);
    ncs_a = 1'b1;
    wait_drain("drain_after_reset");
    idle(8);
    check("reset_mid_valid", 32'(valid_a), 32'd0);
    check("reset_mid_overflow", 32'(ovf_a), 32'd0);
    check("reset_mid_partial", 32'(pd_cnt), 32'd0);

    check("queue_empty_end", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
